// File: rtl/out_fm_buf_to_store_fifo_pkg.sv
// Shared defaults and FSM encoding for the out_fm buffer drain path.
package out_fm_buf_to_store_fifo_pkg;

    localparam int unsigned AW_DEF     = 14;
    localparam int unsigned CW_DEF     = 16;
    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned TM_DEF     = 16;
    localparam int unsigned TR_DEF     = 64;
    localparam int unsigned TC_DEF     = 16;
    localparam int unsigned RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/out_fm_buf_to_store_fifo_data_delay.sv
// Fixed-length delay line; busy_o flags words still behind the output stage.
module out_fm_buf_to_store_fifo_data_delay #(
    parameter int unsigned D  = 1,
    parameter int unsigned DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o,
    output logic          busy_o
);

    if (D < 1) begin : g_depth_check
        $error("data_delay depth must be at least 1");
    end

    logic [DW-1:0] stage_q [D];

    // Shift register, cleared on reset so in-flight words are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(D); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(D); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[D-1];

    // Any non-zero word in the stages before the output stage.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < int'(D) - 1; i++) busy_o = busy_o | (|stage_q[i]);
    end

endmodule

// File: rtl/out_fm_buf_to_store_fifo.sv
// Drains one output-feature-map tile from the out_fm buffer into the store FIFO in (m, r, c) order.
module out_fm_buf_to_store_fifo
    import out_fm_buf_to_store_fifo_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned CW     = CW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned Tm     = TM_DEF,
    parameter int unsigned Tr     = TR_DEF,
    parameter int unsigned Tc     = TC_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_start,
    input  logic [CW-1:0] tile_valid_m,
    input  logic [CW-1:0] tile_valid_row,
    input  logic [CW-1:0] tile_valid_col,
    output logic          out_fm_rd_ena,
    output logic [AW-1:0] out_fm_rd_addr,
    input  logic [DW-1:0] out_fm_rd_data,
    output logic          store_fifo_push,
    output logic [DW-1:0] store_fifo_data,
    input  logic          store_fifo_almost_full,
    output logic          dump_busy,
    output logic          dump_done
);

    localparam int unsigned ROW_STEP = Tc;
    localparam int unsigned CH_STEP  = Tr * Tc;

    if ((64'(Tm) * 64'(Tr) * 64'(Tc)) > (64'(1) << AW)) begin : g_size_check
        $error("Tm*Tr*Tc exceeds the out_fm buffer address space");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] vm_q, vm_d, vr_q, vr_d, vc_q, vc_d;
    logic [CW-1:0] m_q, m_d, r_q, r_d, c_q, c_d;
    logic [AW-1:0] row_base_q, row_base_d, ch_base_q, ch_base_d;
    logic          issue;
    logic          push;
    logic          line_busy;

    // State, latched tile sizes, counters and base addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vm_q       <= '0;
            vr_q       <= '0;
            vc_q       <= '0;
            m_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            row_base_q <= '0;
            ch_base_q  <= '0;
        end else begin
            state_q    <= state_d;
            vm_q       <= vm_d;
            vr_q       <= vr_d;
            vc_q       <= vc_d;
            m_q        <= m_d;
            r_q        <= r_d;
            c_q        <= c_d;
            row_base_q <= row_base_d;
            ch_base_q  <= ch_base_d;
        end
    end

    // Next-state, read issue and incremental (m, r, c) address walk.
    always_comb begin
        state_d    = state_q;
        vm_d       = vm_q;
        vr_d       = vr_q;
        vc_d       = vc_q;
        m_d        = m_q;
        r_d        = r_q;
        c_d        = c_q;
        row_base_d = row_base_q;
        ch_base_d  = ch_base_q;
        issue      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d    = ST_RUN;
                    vm_d       = tile_valid_m;
                    vr_d       = tile_valid_row;
                    vc_d       = tile_valid_col;
                    m_d        = '0;
                    r_d        = '0;
                    c_d        = '0;
                    row_base_d = '0;
                    ch_base_d  = '0;
                end
            end
            ST_RUN: begin
                if ((vm_q == '0) || (vr_q == '0) || (vc_q == '0)) begin
                    state_d = ST_DONE;
                end else if (!store_fifo_almost_full) begin
                    issue = 1'b1;
                    if (c_q == vc_q - CW'(1)) begin
                        c_d = '0;
                        if (r_q == vr_q - CW'(1)) begin
                            r_d        = '0;
                            row_base_d = '0;
                            ch_base_d  = ch_base_q + AW'(CH_STEP);
                            m_d        = m_q + CW'(1);
                            if (m_q == vm_q - CW'(1)) state_d = ST_DRAIN;
                        end else begin
                            r_d        = r_q + CW'(1);
                            row_base_d = row_base_q + AW'(ROW_STEP);
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!line_busy) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read enable travels alongside the buffer read latency to become the push strobe.
    out_fm_buf_to_store_fifo_data_delay #(
        .D  (RD_LAT),
        .DW (1)
    ) u_data_delay (
        .clk    (clk),
        .rst    (rst),
        .d_i    (issue),
        .q_o    (push),
        .busy_o (line_busy)
    );

    assign out_fm_rd_ena   = issue;
    assign out_fm_rd_addr  = issue ? (ch_base_q + row_base_q + AW'(c_q)) : '0;
    assign store_fifo_push = push;
    assign store_fifo_data = push ? out_fm_rd_data : '0;
    assign dump_busy       = (state_q != ST_IDLE);
    assign dump_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_out_fm_buf_to_store_fifo.sv
// Bench: two drain instances (read latency 1 and 3) share tile commands; each has its own buffer and FIFO model.
module tb_out_fm_buf_to_store_fifo;

    localparam int DEPTH1 = 6;
    localparam int DEPTH3 = 8;

    logic        clk;
    logic        rst;
    logic        dump_start;
    logic [15:0] tvm, tvr, tvc;
    logic        af1, af3;
    logic [31:0] rdd1, rdd3;
    logic        ena1, ena3, push1, push3, busy1, busy3, done1, done3;
    logic [13:0] addr1, addr3;
    logic [31:0] fd1, fd3;

    int          cyc = 0;
    int          n_cmp, n_fail;
    bit          rnd_mode;
    int          occ1 = 0, occ3 = 0;
    bit          rb1 = 0, rb3 = 0;
    logic [13:0] ap1;
    logic [13:0] ap3 [3];

    int unsigned expq1[$];
    int unsigned expq3[$];
    int          rd_n [2], push_n [2], done_n [2], done_cyc [2], first_rd [2], first_push [2];

    typedef struct {
        int vm;
        int vr;
        int vc;
        bit rnd;
        int exp_n;
    } vec_t;
    vec_t vt [6];

    out_fm_buf_to_store_fifo #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .dump_start(dump_start),
        .tile_valid_m(tvm), .tile_valid_row(tvr), .tile_valid_col(tvc),
        .out_fm_rd_ena(ena1), .out_fm_rd_addr(addr1), .out_fm_rd_data(rdd1),
        .store_fifo_push(push1), .store_fifo_data(fd1), .store_fifo_almost_full(af1),
        .dump_busy(busy1), .dump_done(done1)
    );

    out_fm_buf_to_store_fifo #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .dump_start(dump_start),
        .tile_valid_m(tvm), .tile_valid_row(tvr), .tile_valid_col(tvc),
        .out_fm_rd_ena(ena3), .out_fm_rd_addr(addr3), .out_fm_rd_data(rdd3),
        .store_fifo_push(push3), .store_fifo_data(fd3), .store_fifo_almost_full(af3),
        .dump_busy(busy3), .dump_done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [13:0] a);
        return {4'hA, a, ~a};
    endfunction

    // Cycle counter, buffer read pipelines, FIFO occupancy with random drain.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ap1    <= addr1;
        ap3[0] <= addr3;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
        rb1    <= ($urandom_range(3, 0) == 0);
        rb3    <= ($urandom_range(3, 0) == 0);
        occ1   <= occ1 + (push1 ? 1 : 0) - (((occ1 > 0) && (!rnd_mode || ($urandom_range(1, 0) == 1))) ? 1 : 0);
        occ3   <= occ3 + (push3 ? 1 : 0) - (((occ3 > 0) && (!rnd_mode || ($urandom_range(1, 0) == 1))) ? 1 : 0);
    end

    assign rdd1 = pat(ap1);
    assign rdd3 = pat(ap3[2]);
    assign af1  = ((DEPTH1 - occ1) < 3) || (rnd_mode && rb1);
    assign af3  = ((DEPTH3 - occ3) < 5) || (rnd_mode && rb3);

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (ena1) begin
                rd_n[0]++;
                if (first_rd[0] < 0) first_rd[0] = cyc;
                chk("dut1_rd_while_af", longint'(af1), 0);
            end
            if (push1) begin
                push_n[0]++;
                if (first_push[0] < 0) first_push[0] = cyc;
                if (expq1.size() == 0) chk("dut1_extra_push", 1, 0);
                else chk("dut1_push_data", longint'(fd1), longint'(pat(14'(expq1.pop_front()))));
                chk("dut1_fifo_overflow", longint'(occ1 > DEPTH1), 0);
            end
            if (done1) begin
                done_n[0]++;
                done_cyc[0] = cyc;
            end
            if (ena3) begin
                rd_n[1]++;
                if (first_rd[1] < 0) first_rd[1] = cyc;
                chk("dut3_rd_while_af", longint'(af3), 0);
            end
            if (push3) begin
                push_n[1]++;
                if (first_push[1] < 0) first_push[1] = cyc;
                if (expq3.size() == 0) chk("dut3_extra_push", 1, 0);
                else chk("dut3_push_data", longint'(fd3), longint'(pat(14'(expq3.pop_front()))));
                chk("dut3_fifo_overflow", longint'(occ3 > DEPTH3), 0);
            end
            if (done3) begin
                done_n[1]++;
                done_cyc[1] = cyc;
            end
        end
    endtask

    // Reference word order: channel, then row, then column; address = m*Tr*Tc + r*Tc + c.
    task automatic build(input int vm, input int vr, input int vc);
        expq1.delete();
        expq3.delete();
        for (int m = 0; m < vm; m++)
            for (int r = 0; r < vr; r++)
                for (int c = 0; c < vc; c++) begin
                    expq1.push_back(int'(m * 64 * 16 + r * 16 + c));
                    expq3.push_back(int'(m * 64 * 16 + r * 16 + c));
                end
        for (int k = 0; k < 2; k++) begin
            rd_n[k] = 0; push_n[k] = 0; done_n[k] = 0;
            done_cyc[k] = -1; first_rd[k] = -1; first_push[k] = -1;
        end
    endtask

    task automatic start(input int vm, input int vr, input int vc, output int t0);
        @(negedge clk);
        tvm = 16'(vm); tvr = 16'(vr); tvc = 16'(vc);
        dump_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        dump_start = 1'b0;
        tvm = 16'($urandom); tvr = 16'($urandom); tvc = 16'($urandom);
    endtask

    task automatic run_tile(input int vm, input int vr, input int vc, input bit rnd,
                            input int exp_n, input bit repulse);
        int t0;
        int w;
        int lat;
        rnd_mode = rnd;
        build(vm, vr, vc);
        start(vm, vr, vc, t0);
        if (repulse) begin
            while (cyc < t0 + 50) @(negedge clk);
            tvm = 16'd1; tvr = 16'd1; tvc = 16'd1;
            dump_start = 1'b1;
            @(negedge clk);
            dump_start = 1'b0;
            while (cyc < t0 + exp_n + 1) @(negedge clk);
            dump_start = 1'b1;
            @(negedge clk);
            dump_start = 1'b0;
        end
        w = 0;
        while (!(done_n[0] > 0 && done_n[1] > 0) && (w < exp_n * 12 + 60)) begin
            @(negedge clk);
            w++;
        end
        repeat (6) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 3;
            chk($sformatf("lat%0d_push_count", lat), push_n[k], exp_n);
            chk($sformatf("lat%0d_rd_count", lat), rd_n[k], exp_n);
            chk($sformatf("lat%0d_done_count", lat), done_n[k], 1);
            if (!rnd) begin
                chk($sformatf("lat%0d_done_cycle", lat), done_cyc[k] - t0,
                    (exp_n == 0) ? 2 : exp_n + lat + 1);
                if (exp_n > 0) begin
                    chk($sformatf("lat%0d_first_rd", lat), first_rd[k] - t0, 1);
                    chk($sformatf("lat%0d_first_push", lat), first_push[k] - t0, 1 + lat);
                end
            end
        end
        chk("lat1_words_left", expq1.size(), 0);
        chk("lat3_words_left", expq3.size(), 0);
        chk("busy_after_done", {busy1, busy3}, 0);
        rnd_mode = 1'b0;
    endtask

    initial begin
        int t0;
        int vm, vr, vc;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; dump_start = 1'b0; rnd_mode = 1'b0;
        tvm = '0; tvr = '0; tvc = '0;
        build(0, 0, 0);
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs_lat1", {ena1, addr1, push1, fd1, busy1, done1}, 0);
        chk("reset_outputs_lat3", {ena3, addr3, push3, fd3, busy3, done3}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", {busy1, busy3}, 0);

        vt[0] = '{vm: 16, vr: 64, vc: 16, rnd: 1'b0, exp_n: 16384};
        vt[1] = '{vm: 3,  vr: 5,  vc: 7,  rnd: 1'b0, exp_n: 105};
        vt[2] = '{vm: 3,  vr: 5,  vc: 7,  rnd: 1'b1, exp_n: 105};
        vt[3] = '{vm: 4,  vr: 4,  vc: 0,  rnd: 1'b0, exp_n: 0};
        vt[4] = '{vm: 2,  vr: 3,  vc: 4,  rnd: 1'b1, exp_n: 24};
        vt[5] = '{vm: 1,  vr: 1,  vc: 1,  rnd: 1'b0, exp_n: 1};
        for (int i = 0; i < 6; i++)
            run_tile(vt[i].vm, vt[i].vr, vt[i].vc, vt[i].rnd, vt[i].exp_n, 1'b0);

        for (int i = 0; i < 4; i++) begin
            vm = int'($urandom_range(4, 1));
            vr = int'($urandom_range(6, 1));
            vc = int'($urandom_range(16, 1));
            run_tile(vm, vr, vc, 1'b1, vm * vr * vc, 1'b0);
        end

        // dump_start while running and while draining is ignored.
        run_tile(3, 5, 7, 1'b0, 105, 1'b1);

        // Reset mid-drain aborts without dump_done, then a full tile drains cleanly.
        rnd_mode = 1'b0;
        build(3, 5, 7);
        start(3, 5, 7, t0);
        while (cyc < t0 + 40) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outputs_lat1", {ena1, addr1, push1, fd1, busy1, done1}, 0);
        chk("abort_outputs_lat3", {ena3, addr3, push3, fd3, busy3, done3}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done_lat1", done_n[0], 0);
        chk("abort_no_done_lat3", done_n[1], 0);
        chk("abort_idle", {busy1, busy3, ena1, ena3, push1, push3}, 0);
        run_tile(16, 64, 16, 1'b0, 16384, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
